// File: rtl/fsm_seq1094.sv
// Moore detector for the ordered digit sequence D0,D1,D2,D3 on a W-bit stream.
// The flag is a dedicated register so it cannot glitch on digit changes.
module fsm_seq1094 #(
    parameter int           W  = 4,
    parameter logic [W-1:0] D0 = W'(1),
    parameter logic [W-1:0] D1 = W'(0),
    parameter logic [W-1:0] D2 = W'(9),
    parameter logic [W-1:0] D3 = W'(4)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in,
    output logic         y
);

    // state | meaning
    // S0    | idle
    // S1    | seen D0
    // S2    | seen D0 D1
    // S3    | seen D0 D1 D2
    // S4    | match, flag high
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    state_t r_state = S0;
    logic   r_y     = 1'b0;
    state_t w_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S0;
            r_y     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_y     <= (w_next == S4);
        end
    end

    always_comb begin
        w_next = S0;
        case (r_state)
            S0: if (in == D0) w_next = S1;
            S1: if (in == D1) w_next = S2;
                else if (in == D0) w_next = S1;
            S2: if (in == D2) w_next = S3;
                else if (in == D0) w_next = S1;
            S3: if (in == D3) w_next = S4;
                else if (in == D0) w_next = S1;
            S4: if (in == D0) w_next = S1;
            // unused encodings fall back to idle
            default: w_next = S0;
        endcase
    end

    assign y = r_y;

endmodule

// File: tb/tb_fsm_seq1094.sv
// Scoreboard bench: stimulus queues the expected flag for each driven digit,
// a monitor compares it 1 ns after the sampling edge.
module tb_fsm_seq1094;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] in    = 4'd7;
    logic       y;

    int   errors = 0;
    int   checks = 0;
    bit   exp_q[$];
    bit   exp_now;
    logic [3:0] ds[$];
    bit         ex[$];

    always #5 clk = ~clk;

    fsm_seq1094 dut (
        .clk   (clk),
        .reset (reset),
        .in    (in),
        .y     (y)
    );

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_now = exp_q.pop_front();
            checks++;
            if (y !== exp_now) begin
                errors++;
                $display("FAIL y_seq: got %b expected %b at %0t", y, exp_now, $time);
            end
        end
    end

    task automatic step(input logic [3:0] d, input logic r, input bit e);
        @(negedge clk);
        in    = d;
        reset = r;
        exp_q.push_back(e);
    endtask

    task automatic run_seq();
        for (int i = 0; i < ds.size(); i++) step(ds[i], 1'b0, ex[i]);
    endtask

    initial begin
        // first edge at 5 ns samples the initial digit 7 with no reset ever applied
        exp_q.push_back(1'b0);
        #1;
        checks++;
        if (y !== 1'b0) begin
            errors++;
            $display("FAIL powerup_y: got %b expected 0", y);
        end

        ds = '{4'd5, 4'd1, 4'd0, 4'd9, 4'd4, 4'd1, 4'd0, 4'd9, 4'd4, 4'd3,
               4'd1, 4'd0, 4'd9, 4'd2, 4'd1, 4'd0, 4'd9, 4'd4, 4'd8};
        ex = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0,
               0, 0, 0, 0, 0, 0, 0, 1, 0};
        run_seq();

        step(4'd1, 1'b1, 1'b0);

        ds = '{4'd1, 4'd0, 4'd1, 4'd0, 4'd9, 4'd4};
        ex = '{0, 0, 0, 0, 0, 1};
        run_seq();

        ds = '{4'd1, 4'd1, 4'd1, 4'd0, 4'd9, 4'd4};
        ex = '{0, 0, 0, 0, 0, 1};
        run_seq();

        ds = '{4'd1, 4'd0, 4'd9, 4'd9, 4'd4, 4'd1, 4'd0, 4'd4, 4'd4};
        ex = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_seq();

        ds = '{4'd1, 4'd0, 4'd9, 4'd15, 4'd4, 4'd12, 4'd1, 4'd0, 4'd9, 4'd4, 4'd4};
        ex = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        run_seq();

        // reset on the edge that samples D3 must win over the match
        ds = '{4'd1, 4'd0, 4'd9};
        ex = '{0, 0, 0};
        run_seq();
        step(4'd4, 1'b1, 1'b0);
        step(4'd4, 1'b0, 1'b0);
        ds = '{4'd1, 4'd0, 4'd9, 4'd4, 4'd0};
        ex = '{0, 0, 0, 1, 0};
        run_seq();

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish by 100000");
        $fatal(1);
    end

endmodule
